// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the combinational ALU.
// Loads A, B and a control byte from the user input bus, one byte per strobe
// rising edge. It then holds the ALU inputs stable for EXEC_CYCLES cycles and
// captures the result and flags. Finally it shows the result byte, then the
// flags byte, on the output bus.
module alu_operand_sequencer #(
   parameter int unsigned EXEC_CYCLES = 2  // legal range 1..15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] in_data,
   input  logic       in_strobe,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   input  logic       alu_negative,
   input  logic       alu_carry,
   input  logic       alu_overflow,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [1:0] alu_shift,
   output logic [2:0] alu_ctrl,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       busy
);

   typedef enum logic [2:0] {
      StLoadA,
      StLoadB,
      StLoadCtrl,
      StExec,
      StResult,
      StFlags
   } state_e;

   // Last counter value of EXEC. A 4-bit counter is enough for 1..15 cycles.
   localparam logic [3:0] LastCnt = 4'(EXEC_CYCLES - 1);

   state_e     r_state;
   logic       r_s1;
   logic       r_s2;
   logic       r_sd;
   logic [3:0] r_cnt;
   logic [3:0] r_flg;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [1:0] r_shift;
   logic [2:0] r_ctrl;
   logic [7:0] r_out_data;
   logic       r_out_valid;
   logic       r_busy;
   logic       w_ev;

   // Rising edge of the synchronised strobe. A level held high gives one event.
   assign w_ev = r_s2 & ~r_sd;

   // Strobe synchroniser, load/exec/display FSM and registered outputs.
   // ena=0 freezes everything, including the synchroniser.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= StLoadA;
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_sd        <= 1'b0;
         r_cnt       <= 4'd0;
         r_flg       <= 4'd0;
         r_a         <= 8'd0;
         r_b         <= 8'd0;
         r_shift     <= 2'd0;
         r_ctrl      <= 3'd0;
         r_out_data  <= 8'd0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (ena) begin
         r_s1 <= in_strobe;
         r_s2 <= r_s1;
         r_sd <= r_s2;
         unique case (r_state)
            StLoadA: begin
               if (w_ev) begin
                  r_a     <= in_data;
                  r_state <= StLoadB;
               end
            end
            StLoadB: begin
               if (w_ev) begin
                  r_b     <= in_data;
                  r_state <= StLoadCtrl;
               end
            end
            StLoadCtrl: begin
               if (w_ev) begin
                  r_ctrl  <= in_data[2:0];
                  r_shift <= in_data[4:3];
                  r_cnt   <= 4'd0;
                  r_busy  <= 1'b1;
                  r_state <= StExec;
               end
            end
            StExec: begin
               // Events are ignored here. The exit compare fires before the counter wraps.
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == LastCnt) begin
                  // out_data holds the captured result for the whole RESULT phase.
                  r_out_data  <= alu_result;
                  r_flg       <= {alu_zero, alu_negative, alu_carry, alu_overflow};
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= StResult;
               end
            end
            StResult: begin
               if (w_ev) begin
                  r_out_data <= {4'b0000, r_flg};
                  r_state    <= StFlags;
               end
            end
            StFlags: begin
               // Operand registers keep their values until they are reloaded.
               if (w_ev) begin
                  r_out_data  <= 8'd0;
                  r_out_valid <= 1'b0;
                  r_state     <= StLoadA;
               end
            end
            default: begin
               r_state <= StLoadA;
            end
         endcase
      end
   end

   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign alu_shift = r_shift;
   assign alu_ctrl  = r_ctrl;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

endmodule
